// File: rtl/rob_core.sv
// In-order reorder buffer: single dispatch, CDB completion, single in-order commit.
// A flushing commit redirects fetch and empties the whole buffer.
module rob_core #(
  parameter int ROB_DEPTH    = 32,
  parameter int ROB_ID_WIDTH = $clog2(ROB_DEPTH),
  parameter int ARCH_WIDTH   = 5,
  parameter int PRF_WIDTH    = 6,
  parameter int HISTORY_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  input  logic [ARCH_WIDTH-1:0]   disp_arch,
  input  logic [PRF_WIDTH-1:0]    disp_phy,
  input  logic [31:0]             disp_pc,
  input  logic                    disp_br_pred_valid,
  input  logic                    disp_br_pred,
  input  logic [HISTORY_BITS-1:0] disp_pht_index,
  output logic                    disp_ready,
  output logic [ROB_ID_WIDTH-1:0] disp_rob_id,
  input  logic                    cdb_valid,
  input  logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
  input  logic                    cdb_br_taken,
  input  logic [31:0]             cdb_pc_next,
  input  logic                    cdb_br_flush,
  output logic                    commit_valid,
  output logic [ARCH_WIDTH-1:0]   commit_arch,
  output logic [PRF_WIDTH-1:0]    commit_phy,
  output logic [31:0]             commit_pc,
  output logic                    commit_br_valid,
  output logic                    commit_br_taken,
  output logic [HISTORY_BITS-1:0] commit_pht_index,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic                    empty
);

  logic [ROB_DEPTH-1:0]    valid_q, ready_q;
  logic [ROB_DEPTH-1:0]    br_pred_valid_q, br_pred_q, br_result_q, br_jal_flush_q;
  logic [ARCH_WIDTH-1:0]   arch_q      [ROB_DEPTH];
  logic [PRF_WIDTH-1:0]    phy_q       [ROB_DEPTH];
  logic [31:0]             pc_q        [ROB_DEPTH];
  logic [31:0]             pc_next_q   [ROB_DEPTH];
  logic [HISTORY_BITS-1:0] pht_index_q [ROB_DEPTH];

  logic [ROB_ID_WIDTH:0]   head_q, tail_q;
  logic [ROB_ID_WIDTH-1:0] head_idx, tail_idx;
  logic                    full, disp_fire, cdb_fire;
  logic                    unused_br_pred;

  assign head_idx = head_q[ROB_ID_WIDTH-1:0];
  assign tail_idx = tail_q[ROB_ID_WIDTH-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[ROB_ID_WIDTH] != tail_q[ROB_ID_WIDTH]);

  assign disp_ready  = !full;
  assign disp_rob_id = tail_idx;

  assign commit_valid     = valid_q[head_idx] && ready_q[head_idx];
  assign commit_arch      = arch_q[head_idx];
  assign commit_phy       = phy_q[head_idx];
  assign commit_pc        = pc_q[head_idx];
  assign commit_br_valid  = br_pred_valid_q[head_idx];
  assign commit_br_taken  = br_result_q[head_idx];
  assign commit_pht_index = pht_index_q[head_idx];

  assign flush    = commit_valid && br_jal_flush_q[head_idx];
  assign flush_pc = flush ? pc_next_q[head_idx] : '0;

  // A flushing commit discards any same-cycle dispatch or completion.
  assign disp_fire = disp_valid && !full && !flush;
  assign cdb_fire  = cdb_valid && valid_q[cdb_rob_id] && !flush;

  // Predicted direction is stored with the entry but not consumed at commit.
  assign unused_br_pred = ^br_pred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (commit_valid) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (disp_fire) begin
        valid_q[tail_idx] <= 1'b1;
        ready_q[tail_idx] <= 1'b0;
        tail_q            <= tail_q + 1'b1;
      end
      if (cdb_fire) begin
        ready_q[cdb_rob_id] <= 1'b1;
      end
    end
  end

  // Payload fields need no reset: they are only observed behind valid && ready.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      arch_q[tail_idx]          <= disp_arch;
      phy_q[tail_idx]           <= disp_phy;
      pc_q[tail_idx]            <= disp_pc;
      pht_index_q[tail_idx]     <= disp_pht_index;
      br_pred_valid_q[tail_idx] <= disp_br_pred_valid;
      br_pred_q[tail_idx]       <= disp_br_pred;
      br_result_q[tail_idx]     <= 1'b0;
      br_jal_flush_q[tail_idx]  <= 1'b0;
    end
    if (cdb_fire) begin
      br_result_q[cdb_rob_id]    <= cdb_br_taken;
      pc_next_q[cdb_rob_id]      <= cdb_pc_next;
      br_jal_flush_q[cdb_rob_id] <= cdb_br_flush;
    end
  end

endmodule

// File: tb/tb_rob_core.sv
// Directed self-checking bench for rob_core: ordering, full/wrap, flush and async reset.
module tb_rob_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic [4:0]  disp_arch;
  logic [5:0]  disp_phy;
  logic [31:0] disp_pc;
  logic        disp_br_pred_valid;
  logic        disp_br_pred;
  logic [7:0]  disp_pht_index;
  logic        disp_ready;
  logic [4:0]  disp_rob_id;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_id;
  logic        cdb_br_taken;
  logic [31:0] cdb_pc_next;
  logic        cdb_br_flush;
  logic        commit_valid;
  logic [4:0]  commit_arch;
  logic [5:0]  commit_phy;
  logic [31:0] commit_pc;
  logic        commit_br_valid;
  logic        commit_br_taken;
  logic [7:0]  commit_pht_index;
  logic        flush;
  logic [31:0] flush_pc;
  logic        empty;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rob_core #(
    .ROB_DEPTH   (32),
    .ROB_ID_WIDTH(5),
    .ARCH_WIDTH  (5),
    .PRF_WIDTH   (6),
    .HISTORY_BITS(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .disp_valid        (disp_valid),
    .disp_arch         (disp_arch),
    .disp_phy          (disp_phy),
    .disp_pc           (disp_pc),
    .disp_br_pred_valid(disp_br_pred_valid),
    .disp_br_pred      (disp_br_pred),
    .disp_pht_index    (disp_pht_index),
    .disp_ready        (disp_ready),
    .disp_rob_id       (disp_rob_id),
    .cdb_valid         (cdb_valid),
    .cdb_rob_id        (cdb_rob_id),
    .cdb_br_taken      (cdb_br_taken),
    .cdb_pc_next       (cdb_pc_next),
    .cdb_br_flush      (cdb_br_flush),
    .commit_valid      (commit_valid),
    .commit_arch       (commit_arch),
    .commit_phy        (commit_phy),
    .commit_pc         (commit_pc),
    .commit_br_valid   (commit_br_valid),
    .commit_br_taken   (commit_br_taken),
    .commit_pht_index  (commit_pht_index),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; disp_arch = '0; disp_phy = '0; disp_pc = '0;
    disp_br_pred_valid = 1'b0; disp_br_pred = 1'b0; disp_pht_index = '0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_br_taken = 1'b0;
    cdb_pc_next = '0; cdb_br_flush = 1'b0;
  endtask

  task automatic set_disp(input logic [4:0] arch, input logic [5:0] phy, input logic [31:0] pc);
    disp_valid = 1'b1; disp_arch = arch; disp_phy = phy; disp_pc = pc;
    disp_br_pred_valid = 1'b0; disp_br_pred = 1'b0; disp_pht_index = '0;
  endtask

  task automatic set_cdb(input logic [4:0] id, input logic [31:0] pc_next, input logic fl);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_pc_next = pc_next;
    cdb_br_taken = fl; cdb_br_flush = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    check("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
    check("rst_flush",        {31'b0, flush},        32'd0);
    check("rst_flush_pc",     flush_pc,              32'd0);
    check("rst_disp_ready",   {31'b0, disp_ready},   32'd1);
    check("rst_disp_rob_id",  {27'b0, disp_rob_id},  32'd0);
    check("rst_empty",        {31'b0, empty},        32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Dispatch three instructions.
    for (int i = 0; i < 3; i++) begin
      set_disp(5'(i + 1), 6'(33 + i), 32'h1000 + 32'(4 * i));
      #1;
      check("disp3_rob_id", {27'b0, disp_rob_id}, 32'(i));
      step();
    end
    idle_inputs();
    #1;
    check("disp3_empty",  {31'b0, empty},        32'd0);
    check("disp3_commit", {31'b0, commit_valid}, 32'd0);

    // Out-of-order completion, in-order retirement.
    set_cdb(5'd2, 32'h100c, 1'b0); step();
    check("ooo_no_commit_2", {31'b0, commit_valid}, 32'd0);
    set_cdb(5'd1, 32'h1008, 1'b0); step();
    check("ooo_no_commit_1", {31'b0, commit_valid}, 32'd0);
    set_cdb(5'd0, 32'h1004, 1'b0); #1;
    check("ooo_no_bypass", {31'b0, commit_valid}, 32'd0);
    step();
    idle_inputs();
    set_disp(5'd4, 6'd36, 32'h100c);
    #1;
    check("c1_valid",     {31'b0, commit_valid},    32'd1);
    check("c1_arch",      {27'b0, commit_arch},     32'd1);
    check("c1_phy",       {26'b0, commit_phy},      32'd33);
    check("c1_pc",        commit_pc,                32'h1000);
    check("c1_br_valid",  {31'b0, commit_br_valid}, 32'd0);
    check("c1_flush",     {31'b0, flush},           32'd0);
    check("c1_disp_id",   {27'b0, disp_rob_id},     32'd3);
    step();
    idle_inputs();
    #1;
    check("c2_valid", {31'b0, commit_valid}, 32'd1);
    check("c2_arch",  {27'b0, commit_arch},  32'd2);
    check("c2_phy",   {26'b0, commit_phy},   32'd34);
    step();
    check("c3_valid", {31'b0, commit_valid}, 32'd1);
    check("c3_arch",  {27'b0, commit_arch},  32'd3);
    step();
    check("c4_none",  {31'b0, commit_valid}, 32'd0);
    check("c4_empty", {31'b0, empty},        32'd0);

    // Fill all 32 entries, then check a rejected 33rd dispatch.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_disp(5'(i), 6'(i), 32'h2000 + 32'(4 * i));
      #1;
      check("fill_ready", {31'b0, disp_ready},  32'd1);
      check("fill_id",    {27'b0, disp_rob_id}, 32'(i));
      step();
    end
    set_disp(5'd31, 6'd63, 32'h3000);
    #1;
    check("full_ready", {31'b0, disp_ready},  32'd0);
    check("full_id",    {27'b0, disp_rob_id}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("full_hold_ready", {31'b0, disp_ready},  32'd0);
    check("full_hold_id",    {27'b0, disp_rob_id}, 32'd0);
    check("full_nonempty",   {31'b0, empty},       32'd0);

    // Full with head completing: commit first, space next cycle, wrap to id 0.
    set_cdb(5'd0, 32'h2004, 1'b0); step();
    idle_inputs();
    #1;
    check("wrap_commit",      {31'b0, commit_valid}, 32'd1);
    check("wrap_commit_pc",   commit_pc,             32'h2000);
    check("wrap_ready_still0", {31'b0, disp_ready},  32'd0);
    step();
    check("wrap_ready", {31'b0, disp_ready},  32'd1);
    check("wrap_id",    {27'b0, disp_rob_id}, 32'd0);
    set_disp(5'd9, 6'd9, 32'h4000);
    step();
    idle_inputs();
    #1;
    check("wrap_full_again", {31'b0, disp_ready},  32'd0);
    check("wrap_tail_id",    {27'b0, disp_rob_id}, 32'd1);

    // Mispredicted branch at head with younger entries pending.
    do_reset();
    set_disp(5'd5, 6'd40, 32'h6000_0000);
    disp_br_pred_valid = 1'b1; disp_br_pred = 1'b0; disp_pht_index = 8'h5a;
    step();
    set_disp(5'd6, 6'd41, 32'h6000_0004); step();
    set_disp(5'd7, 6'd42, 32'h6000_0008); step();
    idle_inputs();
    set_cdb(5'd1, 32'h6000_0008, 1'b0); step();
    set_cdb(5'd0, 32'h6000_0040, 1'b1); step();
    idle_inputs();
    set_disp(5'd8, 6'd43, 32'h6000_000c);
    set_cdb(5'd2, 32'h6000_000c, 1'b0);
    #1;
    check("br_commit",   {31'b0, commit_valid},    32'd1);
    check("br_flush",    {31'b0, flush},           32'd1);
    check("br_flush_pc", flush_pc,                 32'h6000_0040);
    check("br_valid",    {31'b0, commit_br_valid}, 32'd1);
    check("br_taken",    {31'b0, commit_br_taken}, 32'd1);
    check("br_pht",      {24'b0, commit_pht_index}, 32'h5a);
    step();
    idle_inputs();
    #1;
    check("post_flush_empty",  {31'b0, empty},        32'd1);
    check("post_flush_id",     {27'b0, disp_rob_id},  32'd0);
    check("post_flush_flush",  {31'b0, flush},        32'd0);
    check("post_flush_commit", {31'b0, commit_valid}, 32'd0);

    // Asynchronous reset mid-cycle with five entries in flight.
    for (int i = 0; i < 5; i++) begin
      set_disp(5'(i + 10), 6'(i + 10), 32'h7000 + 32'(4 * i));
      step();
    end
    idle_inputs();
    set_cdb(5'd0, 32'h7004, 1'b0);
    #1;
    check("pre_rst_empty", {31'b0, empty}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_empty",  {31'b0, empty},        32'd1);
    check("arst_commit", {31'b0, commit_valid}, 32'd0);
    check("arst_flush",  {31'b0, flush},        32'd0);
    idle_inputs();
    step();
    check("arst_hold_commit", {31'b0, commit_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_after_empty",  {31'b0, empty},        32'd1);
    check("arst_after_id",     {27'b0, disp_rob_id},  32'd0);
    check("arst_after_commit", {31'b0, commit_valid}, 32'd0);
    check("arst_after_flush",  {31'b0, flush},        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_core.md
ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 Parameter ROB_DEPTH, default 32, number of reorder-buffer entries (power of two).
REQ-002 Parameter ROB_ID_WIDTH, default $clog2(ROB_DEPTH)=5, entry index width.
REQ-003 Parameter ARCH_WIDTH, default 5, architectural register index width.
REQ-004 Parameter PRF_WIDTH, default 6, physical register index width.
REQ-005 Parameter HISTORY_BITS, default 8, PHT index width.
REQ-006 Port list, each line giving name, direction, width and meaning:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  1  rename/dispatch presents one instruction.
- disp_arch  in  ARCH_WIDTH  destination architectural register.
- disp_phy  in  PRF_WIDTH  destination physical register.
- disp_pc  in  32  instruction PC.
- disp_br_pred_valid  in  1  instruction is a predicted branch.
- disp_br_pred  in  1  predicted direction.
- disp_pht_index  in  HISTORY_BITS  PHT index used for the prediction.
- disp_ready  out  1  ROB can accept a dispatch this cycle.
- disp_rob_id  out  ROB_ID_WIDTH  ID the presented instruction receives.
- cdb_valid  in  1  completion broadcast.
- cdb_rob_id  in  ROB_ID_WIDTH  completing entry.
- cdb_br_taken  in  1  resolved branch direction.
- cdb_pc_next  in  32  resolved next PC.
- cdb_br_flush  in  1  entry mispredicted or is a redirecting jump.
- commit_valid  out  1  head entry retires this cycle.
- commit_arch  out  ARCH_WIDTH  retiring architectural register.
- commit_phy  out  PRF_WIDTH  retiring physical register.
- commit_pc  out  32  retiring PC.
- commit_br_valid  out  1  retiring entry was a predicted branch.
- commit_br_taken  out  1  resolved direction, for PHT update.
- commit_pht_index  out  HISTORY_BITS  PHT index, for PHT update.
- flush  out  1  pipeline flush request.
- flush_pc  out  32  fetch redirect target.
- empty  out  1  no valid entries.

Function
REQ-007 Storage SHALL be ROB_DEPTH entries, each holding: valid, ready, arch, phy, br_pred_valid, br_pred, br_result, pht_index, pc, pc_next, br_jal_flush.
REQ-008 head and tail SHALL be (ROB_ID_WIDTH+1)-bit pointers; the low bits index the array, the MSB is a wrap bit; increments wrap modulo 2*ROB_DEPTH.
REQ-009 empty SHALL be 1 when head==tail; full when low bits are equal and MSBs differ.
REQ-010 disp_ready SHALL equal !full, combinationally; it does not depend on a same-cycle commit (no bypass).
REQ-011 disp_rob_id SHALL equal tail low bits, combinationally.
REQ-012 When disp_valid && disp_ready && !flush, the entry at tail SHALL be written with valid=1, ready=0, br_result=0, br_jal_flush=0 plus the disp_* fields, and tail SHALL increment.
REQ-013 When cdb_valid and entry[cdb_rob_id].valid, the entry SHALL set ready=1 and capture br_result=cdb_br_taken, pc_next=cdb_pc_next and br_jal_flush=cdb_br_flush; cdb_valid to an invalid entry SHALL be ignored.
REQ-014 A CDB write to the head entry SHALL make it retirable from the next cycle; there is no same-cycle CDB-to-commit bypass.
REQ-015 commit_valid SHALL be asserted combinationally when entry[head].valid && entry[head].ready, with commit_* driven from entry[head] (don't-care otherwise); at most one commit per cycle.
REQ-016 On a commit without br_jal_flush, entry[head].valid SHALL clear and head SHALL increment at the edge.
REQ-017 On a commit with br_jal_flush=1:
- flush=1 and flush_pc=entry[head].pc_next, in the same cycle as commit_valid;
- at the edge, all valid bits clear and head=tail=0;
- a same-cycle dispatch and CDB write are discarded.
REQ-018 flush SHALL be 0 in every other cycle.
REQ-019 A simultaneous dispatch and non-flush commit SHALL both take effect; occupancy is unchanged.

Reset
REQ-020 rst SHALL asynchronously clear all valid/ready bits and set head=tail=0; outputs during and after reset are commit_valid=0, flush=0, flush_pc=0, disp_ready=1, disp_rob_id=0, empty=1.
REQ-021 A reset asserted mid-operation SHALL discard all in-flight entries with no commit or flush issued.

Verification
REQ-022 Reset, then dispatch 3 (arch 1,2,3; phy 33,34,35) -> disp_rob_id 0,1,2; empty=0; no commit.
REQ-023 CDB completes ids 2, 1, 0 on consecutive cycles -> commits arch 1,2,3 in order, on the three cycles after the id-0 completion.
REQ-024 32 dispatches with no completion -> disp_ready=0 after the 32nd; a 33rd disp_valid is ignored and tail is unchanged.
REQ-025 ROB full, head ready -> commit occurs and disp_ready=1 the next cycle; dispatch then lands in id 0 (pointer wrap).
REQ-026 Branch at id 0 completes with cdb_br_flush=1, cdb_pc_next=0x6000_0040, younger entries pending -> flush=1, flush_pc=0x6000_0040 with commit_valid; next cycle empty=1, disp_rob_id=0.
REQ-027 rst pulsed asynchronously mid-cycle with 5 entries valid -> empty=1 immediately; no commit_valid or flush observed.
